// File: rtl/out_spike_accum.sv
// Output-layer spike accumulator: counts spikes per class over one inference window,
// then runs a one-neuron-per-cycle argmax and offers the winner on a valid/ready port.
module out_spike_accum #(
   parameter  int N_OUT   = 10,
   parameter  int T_STEPS = 16,
   parameter  int CNT_W   = 8,
   localparam int IDX_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             outmem_enable,
   input  logic [N_OUT-1:0] spike_in,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_class,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat,
   output logic             busy,
   output logic [1:0]       dbg_state_o
);

   localparam int              STEP_W  = $clog2(T_STEPS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_SCAN  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q [N_OUT];
   logic [CNT_W-1:0]    cnt_d [N_OUT];
   logic [STEP_W-1:0]   step_q;
   logic [STEP_W-1:0]   step_d;
   logic [IDX_W-1:0]    scan_idx_q;
   logic [IDX_W-1:0]    best_idx_q;
   logic [IDX_W-1:0]    best_idx_d;
   logic [CNT_W-1:0]    best_cnt_q;
   logic [CNT_W-1:0]    best_cnt_d;
   logic [CNT_W-1:0]    scan_cnt;
   logic [IDX_W-1:0]    out_class_q;
   logic [CNT_W-1:0]    out_count_q;
   logic                out_sat_q;
   logic                out_valid_q;
   logic                busy_q;
   logic                sat_hit;
   logic                window_done;
   logic                scan_last;
   logic                take_scan;

   // Handshake: a result transfers on any rising edge where out_valid and out_ready are both 1;
   // out_valid never drops and the result fields never change until that edge.
   assign out_valid   = out_valid_q;
   assign out_class   = out_class_q;
   assign out_count   = out_count_q;
   assign out_sat     = out_sat_q;
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

   always_comb begin
      sat_hit = 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (spike_in[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               sat_hit = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      step_d      = step_q + STEP_W'(1);
      window_done = (step_q == STEP_W'(T_STEPS));
      scan_last   = (scan_idx_q == IDX_W'(N_OUT - 1));
      scan_cnt    = cnt_q[scan_idx_q];
      // Index 0 seeds the running best; later indices need a strictly larger count so ties keep the lower index.
      take_scan   = (scan_idx_q == '0) || (scan_cnt > best_cnt_q);
      best_idx_d  = take_scan ? scan_idx_q : best_idx_q;
      best_cnt_d  = take_scan ? scan_cnt : best_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
         step_q      <= '0;
         scan_idx_q  <= '0;
         best_idx_q  <= '0;
         best_cnt_q  <= '0;
         out_class_q <= '0;
         out_count_q <= '0;
         out_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
                  step_q     <= '0;
                  scan_idx_q <= '0;
                  out_sat_q  <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               // The final strobe is counted first; the move to SCAN happens on the following edge.
               if (window_done) begin
                  scan_idx_q <= '0;
                  state_q    <= S_SCAN;
               end else if (outmem_enable) begin
                  for (int i = 0; i < N_OUT; i++) cnt_q[i] <= cnt_d[i];
                  step_q <= step_d;
                  if (sat_hit) out_sat_q <= 1'b1;
               end
            end
            S_SCAN: begin
               best_idx_q <= best_idx_d;
               best_cnt_q <= best_cnt_d;
               if (scan_last) begin
                  out_class_q <= best_idx_d;
                  out_count_q <= best_cnt_d;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  scan_idx_q <= scan_idx_q + IDX_W'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
